// File: rtl/rle_pkg.sv
// Shared definitions for the RLE frame scheduler: FSM encoding and the
// {count, pixel} pair word format written to the destination RAM.
package rle_pkg;

    localparam int PAIR_W = 16;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_PREFILL = 3'd1;
    localparam logic [2:0] ST_FEED    = 3'd2;
    localparam logic [2:0] ST_DRAIN   = 3'd3;
    localparam logic [2:0] ST_FINISH  = 3'd4;

    typedef struct packed {
        logic [7:0] count;
        logic [7:0] pixel;
    } rle_pair_t;

    function automatic logic [PAIR_W-1:0] pack_pair(input rle_pair_t p);
        return {p.count, p.pixel};
    endfunction

    function automatic rle_pair_t unpack_pair(input logic [PAIR_W-1:0] w);
        rle_pair_t p;
        p.count = w[15:8];
        p.pixel = w[7:0];
        return p;
    endfunction

endpackage

// File: rtl/rle_pixel_skid.sv
// Two-entry pixel FIFO between the source RAM and the compressor input;
// push and pop may happen in the same cycle.
module rle_pixel_skid (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic [1:0] occupancy,
    output logic       empty
);

    logic [7:0] entry0;
    logic [7:0] entry1;
    logic [1:0] count;
    logic       pop_ok;
    logic       push_ok;

    assign pop_ok  = pop && (count != 2'd0);
    assign push_ok = push && ((count != 2'd2) || pop_ok);

    // entry0 is always the head; a simultaneous push/pop shifts entry1 forward
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            entry0 <= 8'd0;
            entry1 <= 8'd0;
            count  <= 2'd0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (count == 2'd0) begin
                        entry0 <= push_data;
                    end else begin
                        entry1 <= push_data;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    entry0 <= entry1;
                    count  <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        entry0 <= push_data;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign head      = entry0;
    assign occupancy = count;
    assign empty     = (count == 2'd0);

endmodule

// File: rtl/rle_frame_scheduler.sv
// Drives one rle_compressor across a frame in source RAM, keeping its input
// gap-free, and stores the resulting (count, pixel) pairs in destination RAM.
module rle_frame_scheduler
    import rle_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int OUT_DEPTH = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_start,
    input  logic [15:0]       cfg_frame_len,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       pairs_written,
    output logic              src_re,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [7:0]        src_rdata,
    output logic              dst_we,
    output logic [ADDR_W-1:0] dst_addr,
    output logic [15:0]       dst_wdata,
    output logic              comp_start,
    output logic [7:0]        comp_pixel,
    output logic              comp_valid_in,
    input  logic [7:0]        comp_data,
    input  logic [7:0]        comp_count,
    input  logic              comp_valid_out
);

    logic [2:0]  state;
    logic [15:0] len_q;
    logic [15:0] fetched;
    logic [15:0] accepted;
    logic [15:0] pairs_q;
    logic [16:0] sum_q;
    logic        rd_pend;
    logic        error_q;

    logic [7:0]  skid_head;
    logic [1:0]  skid_occ;
    logic        skid_empty;

    logic        accept;
    logic        last_accept;
    logic        capture;
    logic        overflow_slot;
    logic [16:0] sum_next;
    logic [1:0]  prefill_target;
    logic        prefill_issue;
    logic        prefill_ready;
    logic        feed_issue;
    rle_pair_t   out_pair;

    rle_pixel_skid u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_pend),
        .push_data (src_rdata),
        .pop       (accept),
        .head      (skid_head),
        .occupancy (skid_occ),
        .empty     (skid_empty)
    );

    // The compressor ignores its input on any valid_out cycle, so a pixel
    // only counts as consumed when valid_out is low.
    assign accept        = (state == ST_FEED) && !skid_empty && !comp_valid_out;
    assign last_accept   = accept && (accepted == (len_q - 16'd1));
    assign capture       = comp_valid_out && ((state == ST_FEED) || (state == ST_DRAIN));
    assign overflow_slot = ({1'b0, pairs_q} >= 17'(OUT_DEPTH));
    assign sum_next      = sum_q + {9'd0, comp_count};

    // Prefill stops at two entries (or one for a single-pixel frame) so the
    // buffer can absorb the read that lands during an output bubble.
    assign prefill_target = (len_q == 16'd1) ? 2'd1 : 2'd2;
    assign prefill_issue  = (state == ST_PREFILL) && (fetched < len_q)
                            && ((skid_occ + {1'b0, rd_pend}) < 2'd2);
    assign prefill_ready  = (state == ST_PREFILL) && (skid_occ == prefill_target);
    assign feed_issue     = accept && (fetched < len_q);

    assign out_pair.count = comp_count;
    assign out_pair.pixel = comp_data;

    assign src_re        = prefill_issue || feed_issue;
    assign src_addr      = fetched[ADDR_W-1:0];
    assign comp_start    = prefill_ready;
    assign comp_valid_in = (state == ST_FEED) && !skid_empty;
    assign comp_pixel    = (state == ST_FEED) ? skid_head : 8'd0;
    assign dst_we        = capture && !overflow_slot;
    assign dst_addr      = pairs_q[ADDR_W-1:0];
    assign dst_wdata     = capture ? pack_pair(out_pair) : 16'd0;
    assign busy          = (state == ST_PREFILL) || (state == ST_FEED) || (state == ST_DRAIN);
    assign done          = (state == ST_FINISH);
    assign error         = error_q;
    assign pairs_written = pairs_q;

    // Frame completion is judged by the running count sum, since the
    // compressor's own done flag is sticky across frames.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            len_q    <= 16'd0;
            fetched  <= 16'd0;
            accepted <= 16'd0;
            pairs_q  <= 16'd0;
            sum_q    <= 17'd0;
            rd_pend  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            rd_pend <= src_re;
            if (src_re) begin
                fetched <= fetched + 16'd1;
            end
            if (accept) begin
                accepted <= accepted + 16'd1;
            end
            if (capture) begin
                sum_q   <= sum_next;
                pairs_q <= pairs_q + 16'd1;
                if (overflow_slot) begin
                    error_q <= 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (cfg_start) begin
                        len_q    <= cfg_frame_len;
                        fetched  <= 16'd0;
                        accepted <= 16'd0;
                        pairs_q  <= 16'd0;
                        sum_q    <= 17'd0;
                        error_q  <= (cfg_frame_len == 16'd0);
                        state    <= (cfg_frame_len == 16'd0) ? ST_FINISH : ST_PREFILL;
                    end
                end
                ST_PREFILL: begin
                    if (prefill_ready) begin
                        state <= ST_FEED;
                    end
                end
                ST_FEED: begin
                    if (last_accept) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (capture && (sum_next >= {1'b0, len_q})) begin
                        if (sum_next != {1'b0, len_q}) begin
                            error_q <= 1'b1;
                        end
                        state <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rle_frame_scheduler.sv
// Self-checking bench: two schedulers (default depth and depth 2) around a
// behavioural compressor, checked against a run-length model of each frame.
module tb_rle_frame_scheduler;

    localparam int ADDR_W = 10;
    localparam int DEPTH0 = 1024;
    localparam int DEPTH1 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              cfg_start     [2];
    logic [15:0]       cfg_len       [2];
    logic              busy          [2];
    logic              done          [2];
    logic              error         [2];
    logic [15:0]       pairs_written [2];
    logic              src_re        [2];
    logic [ADDR_W-1:0] src_addr      [2];
    logic [7:0]        src_rdata     [2];
    logic              dst_we        [2];
    logic [ADDR_W-1:0] dst_addr      [2];
    logic [15:0]       dst_wdata     [2];
    logic              comp_start    [2];
    logic [7:0]        comp_pixel    [2];
    logic              comp_valid_in [2];
    logic [7:0]        comp_data     [2];
    logic [7:0]        comp_count    [2];
    logic              comp_valid_out[2];

    logic [7:0]  src_mem   [1024];
    logic [15:0] dst_mem   [2][1024];
    logic [15:0] exp_words [2][1024];
    int          exp_n     [2];
    int          exp_len   [2];
    int          wr_cnt    [2];
    int          acc_idx   [2];
    int          done_cnt  [2];
    int          start_cnt [2];
    int          stall_cnt [2];
    bit          feeding   [2];
    bit          hold_valid[2];
    logic [7:0]  hold_pix  [2];

    int vectors     = 0;
    int miscompares = 0;

    // compressor model state
    bit         cm_active[2];
    bit         cm_have  [2];
    logic [7:0] cm_cur   [2];
    int         cm_cnt   [2];

    rle_frame_scheduler #(.ADDR_W(ADDR_W), .OUT_DEPTH(DEPTH0)) u_dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start[0]), .cfg_frame_len(cfg_len[0]),
        .busy(busy[0]), .done(done[0]), .error(error[0]), .pairs_written(pairs_written[0]),
        .src_re(src_re[0]), .src_addr(src_addr[0]), .src_rdata(src_rdata[0]),
        .dst_we(dst_we[0]), .dst_addr(dst_addr[0]), .dst_wdata(dst_wdata[0]),
        .comp_start(comp_start[0]), .comp_pixel(comp_pixel[0]), .comp_valid_in(comp_valid_in[0]),
        .comp_data(comp_data[0]), .comp_count(comp_count[0]), .comp_valid_out(comp_valid_out[0])
    );

    rle_frame_scheduler #(.ADDR_W(ADDR_W), .OUT_DEPTH(DEPTH1)) u_small (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start[1]), .cfg_frame_len(cfg_len[1]),
        .busy(busy[1]), .done(done[1]), .error(error[1]), .pairs_written(pairs_written[1]),
        .src_re(src_re[1]), .src_addr(src_addr[1]), .src_rdata(src_rdata[1]),
        .dst_we(dst_we[1]), .dst_addr(dst_addr[1]), .dst_wdata(dst_wdata[1]),
        .comp_start(comp_start[1]), .comp_pixel(comp_pixel[1]), .comp_valid_in(comp_valid_in[1]),
        .comp_data(comp_data[1]), .comp_count(comp_count[1]), .comp_valid_out(comp_valid_out[1])
    );

    // Source RAM (one-cycle read latency) and destination RAM capture
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (src_re[k]) src_rdata[k] <= src_mem[src_addr[k]];
            if (dst_we[k]) dst_mem[k][dst_addr[k]] <= dst_wdata[k];
        end
    end

    // Compressor: runs saturate at 255, a new pixel or an input gap emits the
    // pending pair one cycle later, and input is ignored on that output cycle.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                cm_active[k]      <= 1'b0;
                cm_have[k]        <= 1'b0;
                cm_cur[k]         <= 8'd0;
                cm_cnt[k]         <= 0;
                comp_valid_out[k] <= 1'b0;
                comp_data[k]      <= 8'd0;
                comp_count[k]     <= 8'd0;
            end else begin
                comp_valid_out[k] <= 1'b0;
                if (comp_start[k]) begin
                    cm_active[k] <= 1'b1;
                    cm_have[k]   <= 1'b0;
                end else if (cm_active[k] && !comp_valid_out[k]) begin
                    if (comp_valid_in[k]) begin
                        if (cm_have[k] && comp_pixel[k] == cm_cur[k] && cm_cnt[k] < 255) begin
                            cm_cnt[k] <= cm_cnt[k] + 1;
                        end else begin
                            if (cm_have[k]) begin
                                comp_valid_out[k] <= 1'b1;
                                comp_data[k]      <= cm_cur[k];
                                comp_count[k]     <= 8'(cm_cnt[k]);
                            end
                            cm_have[k] <= 1'b1;
                            cm_cur[k]  <= comp_pixel[k];
                            cm_cnt[k]  <= 1;
                        end
                    end else if (cm_have[k]) begin
                        comp_valid_out[k] <= 1'b1;
                        comp_data[k]      <= cm_cur[k];
                        comp_count[k]     <= 8'(cm_cnt[k]);
                        cm_have[k]        <= 1'b0;
                        cm_active[k]      <= 1'b0;
                    end
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected pair list for a frame: plain run-length encoding, runs capped at 255
    task automatic build_expected(input int k, input int len);
        logic [7:0] cur;
        int cnt;
        exp_n[k] = 0; exp_len[k] = len; wr_cnt[k] = 0; acc_idx[k] = 0;
        done_cnt[k] = 0; start_cnt[k] = 0; stall_cnt[k] = 0;
        cur = 8'd0; cnt = 0;
        for (int i = 0; i < len; i++) begin
            if (cnt != 0 && src_mem[i] == cur && cnt < 255) begin
                cnt++;
            end else begin
                if (cnt != 0) begin
                    exp_words[k][exp_n[k]] = {8'(cnt), cur};
                    exp_n[k]++;
                end
                cur = src_mem[i];
                cnt = 1;
            end
        end
        if (cnt != 0) begin
            exp_words[k][exp_n[k]] = {8'(cnt), cur};
            exp_n[k]++;
        end
    endtask

    // Per-cycle checker: write stream, pixel order, gap-free feed, held pixels
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                feeding[k]    = 1'b0;
                hold_valid[k] = 1'b0;
            end else begin
                if (done[k]) done_cnt[k]++;
                if (comp_start[k]) start_cnt[k]++;
                if (comp_valid_in[k] && comp_valid_out[k]) stall_cnt[k]++;
                if (hold_valid[k]) check_output("held_pixel", comp_pixel[k], hold_pix[k]);
                hold_valid[k] = comp_valid_in[k] && comp_valid_out[k];
                hold_pix[k]   = comp_pixel[k];
                if (feeding[k]) check_output("feed_gap", comp_valid_in[k], 1);
                if (comp_valid_in[k] && !comp_valid_out[k]) begin
                    check_output("pixel_order", comp_pixel[k], src_mem[acc_idx[k] % 1024]);
                    acc_idx[k]++;
                    if (acc_idx[k] >= exp_len[k]) feeding[k] = 1'b0;
                end
                if (comp_start[k]) feeding[k] = 1'b1;
                if (dst_we[k]) begin
                    if (wr_cnt[k] < exp_n[k] && wr_cnt[k] < (k == 0 ? DEPTH0 : DEPTH1)) begin
                        check_output("dst_addr", dst_addr[k], wr_cnt[k]);
                        check_output("dst_wdata", dst_wdata[k], exp_words[k][wr_cnt[k]]);
                    end else begin
                        vectors++;
                        miscompares++;
                        $display("[TB] FAIL extra_write: got write #%0d expected at most %0d", wr_cnt[k], exp_n[k]);
                    end
                    wr_cnt[k]++;
                end
            end
        end
    end

    task automatic check_idle_outputs(input int k);
        check_output("idle_busy", busy[k], 0);
        check_output("idle_done", done[k], 0);
        check_output("idle_error", error[k], 0);
        check_output("idle_pairs", pairs_written[k], 0);
        check_output("idle_src_re", src_re[k], 0);
        check_output("idle_src_addr", src_addr[k], 0);
        check_output("idle_dst_we", dst_we[k], 0);
        check_output("idle_dst_addr", dst_addr[k], 0);
        check_output("idle_dst_wdata", dst_wdata[k], 0);
        check_output("idle_comp_start", comp_start[k], 0);
        check_output("idle_comp_pixel", comp_pixel[k], 0);
        check_output("idle_comp_valid", comp_valid_in[k], 0);
    endtask

    task automatic apply_stimulus(input int k, input int len, input bit poke);
        bit seen;
        int depth;
        depth = (k == 0) ? DEPTH0 : DEPTH1;
        @(posedge clk); #1;
        build_expected(k, len);
        cfg_len[k]   = 16'(len);
        cfg_start[k] = 1'b1;
        @(posedge clk); #1;
        cfg_start[k] = 1'b0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (poke && cyc == 5) begin
                cfg_len[k]   = 16'd5;
                cfg_start[k] = 1'b1;
            end else begin
                cfg_start[k] = 1'b0;
            end
            if (done[k]) begin
                seen = 1'b1;
                break;
            end
        end
        cfg_start[k] = 1'b0;
        check_output("done_seen", seen, 1);
        repeat (3) @(negedge clk);
        check_output("done_pulses", done_cnt[k], 1);
        check_output("start_pulses", start_cnt[k], (len == 0) ? 0 : 1);
        check_output("busy_after", busy[k], 0);
        check_output("error", error[k], (len == 0 || exp_n[k] > depth) ? 1 : 0);
        check_output("pairs_written", pairs_written[k], exp_n[k]);
        check_output("write_count", wr_cnt[k], (exp_n[k] < depth) ? exp_n[k] : depth);
        check_output("pixels_accepted", acc_idx[k], len);
    endtask

    initial begin
        bit seen;
        rst_n = 1'b0;
        cfg_start[0] = 1'b0; cfg_start[1] = 1'b0;
        cfg_len[0] = 16'd0;  cfg_len[1] = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs(0);
        check_idle_outputs(1);
        rst_n = 1'b1;

        // short frame with two runs and a single
        src_mem[0] = 8'd5; src_mem[1] = 8'd5; src_mem[2] = 8'd5;
        src_mem[3] = 8'd9; src_mem[4] = 8'd9; src_mem[5] = 8'd1;
        apply_stimulus(0, 6, 1'b0);
        check_output("t6_word0", dst_mem[0][0], 16'h0305);
        check_output("t6_word1", dst_mem[0][1], 16'h0209);
        check_output("t6_word2", dst_mem[0][2], 16'h0101);

        // single pixel
        src_mem[0] = 8'h7F;
        apply_stimulus(0, 1, 1'b0);
        check_output("t1_word0", dst_mem[0][0], 16'h017F);
        check_output("t1_stalls", stall_cnt[0], 0);

        // 300 identical pixels split at 255, with a cfg_start while busy
        for (int i = 0; i < 300; i++) src_mem[i] = 8'hAA;
        apply_stimulus(0, 300, 1'b1);
        check_output("t300_word0", dst_mem[0][0], 16'hFFAA);
        check_output("t300_word1", dst_mem[0][1], 16'h2DAA);

        // alternating pixels: an output bubble after every accept
        for (int i = 0; i < 8; i++) src_mem[i] = (i % 2 == 0) ? 8'd1 : 8'd2;
        apply_stimulus(0, 8, 1'b0);
        check_output("alt_word0", dst_mem[0][0], 16'h0101);
        check_output("alt_word7", dst_mem[0][7], 16'h0102);

        // runs of three
        for (int i = 0; i < 40; i++) src_mem[i] = 8'(i / 3 + 16);
        apply_stimulus(0, 40, 1'b0);
        check_output("run3_word0", dst_mem[0][0], 16'h0310);
        check_output("run3_word13", dst_mem[0][13], 16'h011D);

        // destination overflow on the depth-2 instance
        for (int i = 0; i < 4; i++) src_mem[i] = 8'(i + 1);
        apply_stimulus(1, 4, 1'b0);
        check_output("ovf_word1", dst_mem[1][1], 16'h0102);
        check_output("ovf_pairs_lit", pairs_written[1], 4);

        // error clears on the next accepted frame
        src_mem[0] = 8'd3; src_mem[1] = 8'd3;
        apply_stimulus(1, 2, 1'b0);
        check_output("clr_word0", dst_mem[1][0], 16'h0203);

        // reset in the middle of a frame
        src_mem[0] = 8'd5; src_mem[1] = 8'd5; src_mem[2] = 8'd5;
        src_mem[3] = 8'd9; src_mem[4] = 8'd9; src_mem[5] = 8'd1;
        @(posedge clk); #1;
        build_expected(0, 6);
        cfg_len[0] = 16'd6;
        cfg_start[0] = 1'b1;
        @(posedge clk); #1;
        cfg_start[0] = 1'b0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            @(negedge clk);
            if (comp_start[0]) begin
                seen = 1'b1;
                break;
            end
        end
        check_output("mid_start_seen", seen, 1);
        repeat (2) @(negedge clk);
        check_output("mid_busy", busy[0], 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs(0);
        check_output("mid_no_done", done_cnt[0], 0);
        rst_n = 1'b1;

        // zero-length frame after the abandoned one
        apply_stimulus(0, 0, 1'b0);

        $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rle_frame_scheduler.md
Name: rle_frame_scheduler

Overview:
- Sequences one rle_compressor instance over a frame stored in a source pixel RAM and packs its (pixel, count) pairs into a destination RAM.
- Fetches pixels, pulses the compressor start, and keeps the compressor's valid_in gap-free, because any gap mid-frame triggers a premature flush.
- Stalls across the compressor's one-cycle OUTPUT bubble, drains the final flush pair, and reports completion and overflow.

Parameters:
ADDR_W, 10, address width of source and destination RAMs (MEM_SIZE = 2**ADDR_W)
OUT_DEPTH, 1024, destination RAM capacity in pair words

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
cfg_start  in  1  one-cycle frame request; ignored unless busy=0
cfg_frame_len  in  16  pixels in frame, sampled on accepted cfg_start
busy  out  1  high from accepted cfg_start until done
done  out  1  one-cycle completion pulse
error  out  1  sticky until next accepted cfg_start: overflow, zero length, or count-sum mismatch
pairs_written  out  16  pairs stored for current/last frame
src_re  out  1  source RAM read enable
src_addr  out  ADDR_W  source read address
src_rdata  in  8  source data, valid one cycle after src_re
dst_we  out  1  destination write enable
dst_addr  out  ADDR_W  destination write address
dst_wdata  out  16  {count[7:0], pixel[7:0]}
comp_start  out  1  to compressor start
comp_pixel  out  8  to compressor pixel_in
comp_valid_in  out  1  to compressor valid_in
comp_data  in  8  from compressor data_out
comp_count  in  8  from compressor count_out
comp_valid_out  in  1  from compressor valid_out

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE; all outputs 0; skid buffer emptied; counters cleared. Reset mid-frame abandons the frame with no done. The system resets the compressor on the same reset.
- States: IDLE, PREFILL, FEED, DRAIN, FINISH.
- IDLE + cfg_start:
  - Latch len, clear error, pairs_written, fetch/accept counters and the count accumulator sum.
  - len=0: go straight to FINISH with error=1, no compressor activity.
  - Otherwise go to PREFILL.
- PREFILL:
  - Issue src reads at addresses 0,1,... into the skid buffer.
  - When the buffer holds min(2, len) entries, assert comp_start for exactly that cycle, then enter FEED.
- FEED:
  - comp_valid_in = buffer non-empty; comp_pixel = buffer head.
  - Pixel accepted only when comp_valid_in=1 and comp_valid_out=0. comp_valid_out=1 marks the compressor OUTPUT/IDLE cycle, which ignores input, so the head is held and re-presented.
  - On accept: pop; a refill read is issued in the same cycle while fetched<len. The buffer must never go empty while accepted<len (bench assertion).
  - After the len-th accept, deassert comp_valid_in and enter DRAIN.
- Pair capture (FEED and DRAIN), each comp_valid_out=1 cycle:
  - Write {comp_count, comp_data} to dst_addr=pairs_written.
  - sum += comp_count; pairs_written++.
  - If pairs_written==OUT_DEPTH: suppress the write, set error, and keep counting sum.
- DRAIN: exits to FINISH when a pair arrives and the new sum == len. sum > len sets error and also exits.
- FINISH: done=1 for one cycle, busy=0, then IDLE.
- Widths: sum is 17 bits; counters are 16 bits; src_addr and dst_addr are truncated to ADDR_W (len > 2**ADDR_W is a caller error, not checked).
- cfg_start while busy: ignored.
- End detection uses the count sum, not compressor done, which is sticky.

Decomposition:
- Package rle_pkg: state encoding, PAIR_W=16, pack/unpack helpers for {count, pixel}.
- Sub-module rle_pixel_skid: 2-entry 8-bit FIFO with push, pop, head, occupancy; push and pop may be simultaneous.

Test Plan:
- len=6, pixels 5,5,5,9,9,1 -> dst words 0x0305, 0x0209, 0x0101; pairs_written=3; done once; error=0.
- len=1, pixel 0x7F -> single word 0x017F; done; no stall cycles observed.
- len=300 all 0xAA -> words 0xFFAA, 0x2DAA; sum=300.
- Alternating 1,2,1,2 (len=8) -> 8 words 0x0101/0x0102; every comp_valid_out cycle holds comp_pixel stable; no pixel lost.
- OUT_DEPTH=2, len=4 distinct pixels -> only 2 writes, error=1, done still pulses, pairs_written=4.
- rst_n low mid-FEED -> next cycle all outputs 0, state IDLE; new cfg_start len=0 -> done pulse with error=1, comp_start never asserted.
